// File: rtl/fetch_decode_ctrl.sv
// Purpose : multicycle fetch/decode front-end; holds the PC, reads a synchronous ROM,
//           decodes addi/add/bne into datapath controls and resolves bne from EQ.
// Latency : three cycles per instruction (FETCH, DECODE, EXECUTE); no backpressure,
//           'en' only gates the start of a new fetch, an illegal opcode parks in HALT.
// Ports   : clk/rst (sync, active-high); en run enable; imem_addr/imem_rdata ROM
//           interface (data one cycle after address); EQ branch flag from the ALU;
//           rs1/rs2/rd/RegWrite/ImmOp/ALUsrc/ALUctrl datapath controls; pc; halted.
module fetch_decode_ctrl #(
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    ADD_WIDTH       = 5,
    parameter int                    IMEM_ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]      imem_rdata,
    input  logic                       EQ,
    output logic [ADD_WIDTH-1:0]       rs1,
    output logic [ADD_WIDTH-1:0]       rs2,
    output logic [ADD_WIDTH-1:0]       rd,
    output logic                       RegWrite,
    output logic [DATA_WIDTH-1:0]      ImmOp,
    output logic                       ALUsrc,
    output logic                       ALUctrl,
    output logic [DATA_WIDTH-1:0]      pc,
    output logic                       halted
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] pc_nxt;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_b;
    logic                  is_addi, is_add, is_bne;
    logic                  rdata_legal;

    assign imem_addr = pc[IMEM_ADDR_WIDTH-1:0];

    // Register fields are passed through raw; gating happens on the enables only.
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign rd  = ir[11:7];

    assign is_addi = (ir[6:0] == OP_IMM)    && (ir[14:12] == 3'b000);
    assign is_add  = (ir[6:0] == OP_REG)    && (ir[14:12] == 3'b000) && (ir[31:25] == 7'b0000000);
    assign is_bne  = (ir[6:0] == OP_BRANCH) && (ir[14:12] == 3'b001);

    // Legality is judged on the ROM word itself so DECODE can branch to HALT
    // in the same cycle the word is captured into IR.
    assign rdata_legal =
        ((imem_rdata[6:0] == OP_IMM)    && (imem_rdata[14:12] == 3'b000)) ||
        ((imem_rdata[6:0] == OP_REG)    && (imem_rdata[14:12] == 3'b000) &&
         (imem_rdata[31:25] == 7'b0000000)) ||
        ((imem_rdata[6:0] == OP_BRANCH) && (imem_rdata[14:12] == 3'b001));

    assign imm_i = {{(DATA_WIDTH-12){ir[31]}}, ir[31:20]};
    assign imm_b = {{(DATA_WIDTH-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FETCH;
            pc     <= RESET_PC;
            ir     <= '0;
            halted <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == S_DECODE) begin
                ir <= imem_rdata;
                if (!rdata_legal) begin
                    halted <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        RegWrite  = 1'b0;
        ALUsrc    = 1'b0;
        ALUctrl   = 1'b0;
        ImmOp     = '0;
        case (state)
            S_FETCH: begin
                if (en) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nxt = rdata_legal ? S_EXECUTE : S_HALT;
            end
            S_EXECUTE: begin
                state_nxt = S_FETCH;
                // Taken bne adds the branch offset; everything else steps one word.
                // Wrap-around at the top of the address space is intentional.
                pc_nxt = pc + ((is_bne && !EQ) ? imm_b : DATA_WIDTH'(4));
                // Controls are suppressed while rst is high so a reset landing
                // mid-EXECUTE never writes the register file.
                if (!rst) begin
                    RegWrite = is_addi || is_add;
                    ALUsrc   = is_addi;
                    ALUctrl  = is_bne;
                    if (is_addi) begin
                        ImmOp = imm_i;
                    end else if (is_bne) begin
                        ImmOp = imm_b;
                    end
                end
            end
            default: begin
                state_nxt = S_HALT;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed bench for fetch_decode_ctrl: a word-indexed synchronous ROM and a small
// register-file/ALU model sit around the DUT; EQ is driven directly by the bench.
module tb_fetch_decode_ctrl;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        eq;
    logic [4:0]  rs1, rs2, rd;
    logic        RegWrite;
    logic [31:0] ImmOp;
    logic        ALUsrc;
    logic        ALUctrl;
    logic [31:0] pc;
    logic        halted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rom  [0:63];
    logic [31:0] regs [0:31];
    logic        rf_clr;
    int          wr_cnt;

    localparam logic [31:0] I_ADDI = 32'h00500513;   // addi x10,x0,5
    localparam logic [31:0] I_ADD  = 32'h00A505B3;   // add  x11,x10,x10
    localparam logic [31:0] I_BNE  = 32'hFE051EE3;   // bne  x10,x0,-4

    fetch_decode_ctrl #(
        .DATA_WIDTH(32), .ADD_WIDTH(5), .IMEM_ADDR_WIDTH(8), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .EQ(eq),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .RegWrite(RegWrite), .ImmOp(ImmOp), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
        .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    // Synchronous ROM; the low two address bits are ignored.
    always @(posedge clk) imem_rdata <= rom[imem_addr[7:2]];

    // Register file + ALU model fed by the DUT's controls.
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
            wr_cnt <= 0;
        end else if (RegWrite) begin
            wr_cnt <= wr_cnt + 1;
            if (rd != 5'd0)
                regs[rd] <= ALUsrc ? regs[rs1] + ImmOp :
                            (ALUctrl ? regs[rs1] - regs[rs2] : regs[rs1] + regs[rs2]);
        end
    end

    task automatic pulse_reset();
        rst = 1'b1; en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; eq = 1'b0; rf_clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, 32'h0); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", halted); end
        n_tests++; if ({RegWrite, ALUsrc, ALUctrl} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got %b want 000", {RegWrite, ALUsrc, ALUctrl}); end
        n_tests++; if (ImmOp !== 32'h0) begin n_fail++; $display("FAIL reset_imm got %h want 0", ImmOp); end
        n_tests++; if ({rs1, rs2, rd} !== 15'h0) begin n_fail++; $display("FAIL reset_regaddr got %h want 0", {rs1, rs2, rd}); end
        rst = 1'b0; rf_clr = 1'b0;
    endtask

    task automatic test_addi();
        en = 1'b1;
        @(negedge clk);                       // DECODE
        n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL addi_decode_rw got %b want 0", RegWrite); end
        @(negedge clk);                       // EXECUTE
        en = 1'b0;
        n_tests++; if ({rs1, rd} !== {5'd0, 5'd10}) begin n_fail++; $display("FAIL addi_fields got rs1=%0d rd=%0d want 0/10", rs1, rd); end
        n_tests++; if (ImmOp !== 32'd5) begin n_fail++; $display("FAIL addi_imm got %h want 5", ImmOp); end
        n_tests++; if ({RegWrite, ALUsrc, ALUctrl} !== 3'b110) begin n_fail++; $display("FAIL addi_ctrl got %b want 110", {RegWrite, ALUsrc, ALUctrl}); end
        @(negedge clk);                       // FETCH
        n_tests++; if (pc !== 32'd4) begin n_fail++; $display("FAIL addi_pc got %h want 4", pc); end
        n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL addi_rw_pulse got %b want 0", RegWrite); end
        n_tests++; if (regs[10] !== 32'd5) begin n_fail++; $display("FAIL addi_a0 got %h want 5", regs[10]); end
        n_tests++; if (imem_addr !== 8'h04) begin n_fail++; $display("FAIL addi_imem_addr got %h want 04", imem_addr); end
    endtask

    task automatic test_add();
        en = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b0;
        n_tests++; if ({rs1, rs2, rd} !== {5'd10, 5'd10, 5'd11}) begin n_fail++; $display("FAIL add_fields got %0d/%0d/%0d want 10/10/11", rs1, rs2, rd); end
        n_tests++; if ({RegWrite, ALUsrc, ALUctrl} !== 3'b100) begin n_fail++; $display("FAIL add_ctrl got %b want 100", {RegWrite, ALUsrc, ALUctrl}); end
        n_tests++; if (ImmOp !== 32'h0) begin n_fail++; $display("FAIL add_imm got %h want 0", ImmOp); end
        @(negedge clk);
        n_tests++; if (pc !== 32'd8) begin n_fail++; $display("FAIL add_pc got %h want 8", pc); end
        n_tests++; if (regs[11] !== 32'd10) begin n_fail++; $display("FAIL add_a1 got %h want a", regs[11]); end
    endtask

    task automatic test_bne();
        // Taken branch from pc=8 back to 4.
        eq = 1'b0; en = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b0;
        n_tests++; if (ImmOp !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL bne_imm got %h want fffffffc", ImmOp); end
        n_tests++; if ({RegWrite, ALUsrc, ALUctrl} !== 3'b001) begin n_fail++; $display("FAIL bne_ctrl got %b want 001", {RegWrite, ALUsrc, ALUctrl}); end
        n_tests++; if ({rs1, rs2} !== {5'd10, 5'd0}) begin n_fail++; $display("FAIL bne_fields got %0d/%0d want 10/0", rs1, rs2); end
        @(negedge clk);
        n_tests++; if (pc !== 32'd4) begin n_fail++; $display("FAIL bne_taken_pc got %h want 4", pc); end
        // Re-run add (pc 4 -> 8), then not-taken bne.
        en = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_tests++; if (pc !== 32'd8) begin n_fail++; $display("FAIL bne_readd_pc got %h want 8", pc); end
        eq = 1'b1; en = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_tests++; if (pc !== 32'd12) begin n_fail++; $display("FAIL bne_not_taken_pc got %h want c", pc); end
        eq = 1'b0;
    endtask

    task automatic test_reset_mid();
        int wc;
        pulse_reset();
        en = 1'b1;
        repeat (2) @(negedge clk);            // EXECUTE of addi
        n_tests++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL mid_pre_rw got %b want 1", RegWrite); end
        rst = 1'b1; en = 1'b0;
        #1;
        n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rw got %b want 0", RegWrite); end
        wc = wr_cnt;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (wr_cnt !== wc) begin n_fail++; $display("FAIL mid_no_write got %0d writes want %0d", wr_cnt, wc); end
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL mid_pc got %h want 0", pc); end
    endtask

    task automatic test_en_hold();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_tests++; if ({pc, RegWrite, ALUsrc, ALUctrl, ImmOp} !== {32'h0, 3'b000, 32'h0}) begin
                n_fail++; $display("FAIL hold_static cycle %0d got pc=%h ctrl=%b imm=%h want 0", i, pc, {RegWrite, ALUsrc, ALUctrl}, ImmOp);
            end
        end
        en = 1'b1;
        @(negedge clk);                       // DECODE; dropping en must not abort
        en = 1'b0;
        n_tests++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL resume_decode_rw got %b want 0", RegWrite); end
        @(negedge clk);
        n_tests++; if (RegWrite !== 1'b1) begin n_fail++; $display("FAIL resume_exec_rw got %b want 1", RegWrite); end
        @(negedge clk);
        n_tests++; if (pc !== 32'd4) begin n_fail++; $display("FAIL resume_pc got %h want 4", pc); end
    endtask

    task automatic test_illegal();
        rom[0] = 32'h00000000;
        pulse_reset();
        en = 1'b1;
        @(negedge clk);                       // DECODE
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL ill_early_halt got %b want 0", halted); end
        @(negedge clk);                       // HALT
        n_tests++; if (halted !== 1'b1) begin n_fail++; $display("FAIL ill_halted got %b want 1", halted); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++; if ({halted, pc, RegWrite, ALUsrc, ALUctrl, ImmOp} !== {1'b1, 32'h0, 3'b000, 32'h0}) begin
                n_fail++; $display("FAIL ill_hold cycle %0d got h=%b pc=%h ctrl=%b imm=%h", i, halted, pc, {RegWrite, ALUsrc, ALUctrl}, ImmOp);
            end
        end
        rom[0] = I_ADDI;
        pulse_reset();
        n_tests++; if ({halted, pc} !== {1'b0, 32'h0}) begin n_fail++; $display("FAIL ill_recover got h=%b pc=%h want 0/0", halted, pc); end
    endtask

    task automatic test_wrap();
        rom[0]  = I_BNE;
        rom[63] = I_ADDI;
        pulse_reset();
        eq = 1'b0; en = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_tests++; if (pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL wrap_branch_pc got %h want fffffffc", pc); end
        n_tests++; if (imem_addr !== 8'hFC) begin n_fail++; $display("FAIL wrap_imem_addr got %h want fc", imem_addr); end
        en = 1'b1;
        repeat (2) @(negedge clk);
        en = 1'b0;
        n_tests++; if ({RegWrite, ImmOp} !== {1'b1, 32'd5}) begin n_fail++; $display("FAIL wrap_exec got rw=%b imm=%h want 1/5", RegWrite, ImmOp); end
        @(negedge clk);
        n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h want 0", pc); end
        rom[0] = I_ADDI;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; en = 1'b0; eq = 1'b0; rf_clr = 1'b1;
        for (int i = 0; i < 64; i++) rom[i] = 32'h0;
        rom[0] = I_ADDI;
        rom[1] = I_ADD;
        rom[2] = I_BNE;
        test_reset();
        test_addi();
        test_add();
        test_bne();
        test_reset_mid();
        test_en_hold();
        test_illegal();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
